// File: rtl/io_output_uart.sv
// io_output_uart: responder on the CPU word-output req/ack channel.
// Buffers 16-bit words in a small FIFO and sends each one on a UART TX line
// as two 8N1 frames, low byte first.
module io_output_uart #(
    parameter int WORD_SIZE    = 16,
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       req,
    output logic                       ack,
    input  logic [WORD_SIZE-1:0]       data,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CLK_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [CLK_W-1:0] LAST_CLK   = CLK_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state_q, state_d;
    logic [CLK_W-1:0]       clk_cnt_q, clk_cnt_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   byte_sel_q, byte_sel_d;
    logic [WORD_SIZE-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   ack_q, ack_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [WORD_SIZE-1:0]   mem_q [DEPTH];

    logic push;
    logic pop;
    logic bit_done;

    // Accept decision uses the pre-edge count, so a same-edge pop never unblocks a push.
    always_comb begin
        push     = req && !ack_q && (count_q < FULL_COUNT);
        ack_d    = push;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end

    // FIFO storage; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // State register for the FIFO control, TX FSM and registered outputs.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_sel_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ack_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_sel_q <= byte_sel_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ack_q      <= ack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic; the end of a word chains straight into the next one when the FIFO holds data.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_sel_d = byte_sel_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        bit_done   = (clk_cnt_q == LAST_CLK);
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (count_q != '0) begin
                    pop        = 1'b1;
                    shift_d    = mem_q[rd_ptr_q];
                    byte_sel_d = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    clk_cnt_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        state_d    = START;
                    end else if (count_q != '0) begin
                        pop        = 1'b1;
                        shift_d    = mem_q[rd_ptr_q];
                        byte_sel_d = 1'b0;
                        state_d    = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic; tx is computed from the next state so the registered line lines up with the FSM.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[{byte_sel_d, bit_cnt_d}];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign ack        = ack_q;
    assign fifo_count = count_q;
    assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_io_output_uart.sv
// Scoreboard bench for io_output_uart: words go into a queue as they are
// accepted and a UART receiver model pops and compares them.
module tb_io_output_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        areset;
    logic        req;
    logic        ack;
    logic [15:0] data;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_count;

    int          checks;
    int          errors;
    int          cyc;
    int          decoded;
    int          max_count;
    logic [15:0] sb [$];

    io_output_uart #(
        .WORD_SIZE    (16),
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .req        (req),
        .ack        (ack),
        .data       (data),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // Free-running clock and a cycle counter for latency measurements.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Tracks the highest FIFO occupancy seen since the last clear.
    always @(negedge clk) begin
        if (fifo_count > max_count[2:0]) max_count = int'(fifo_count);
    end

    // Counts one comparison and reports it if the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Presents one word and waits for its ack; hold keeps req high for a following word.
    task automatic applyStimulus(input logic [15:0] word, input bit hold);
        int waited;
        data   = word;
        req    = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ack && waited < 300);
        if (!ack) checkOutput("ackTimeout", 32'd0, 32'd1);
        else sb.push_back(word);
        if (!hold) req = 1'b0;
    endtask

    // Waits, with a bound, for the transmitter to go idle.
    task automatic waitIdle();
        int waited;
        waited = 0;
        while (busy && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (busy) checkOutput("idleTimeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    // UART receiver model: samples mid-bit, rebuilds words low byte first, and abandons a frame on reset.
    initial begin : decoder
        logic [7:0] rx_byte;
        logic [7:0] low_byte;
        logic       have_low;
        logic       aborted;
        have_low = 1'b0;
        rx_byte  = '0;
        low_byte = '0;
        forever begin
            @(negedge clk);
            if (!areset) begin
                have_low = 1'b0;
            end else if (tx == 1'b0) begin
                aborted = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    if (k == 0) repeat (CPB / 2) @(negedge clk);
                    else        repeat (CPB) @(negedge clk);
                    if (!areset) aborted = 1'b1;
                    if (!aborted) begin
                        if (k == 0)      checkOutput("startBit", {31'd0, tx}, 32'd0);
                        else if (k == 9) checkOutput("stopBit", {31'd0, tx}, 32'd1);
                        else             rx_byte[k-1] = tx;
                    end
                end
                if (aborted) begin
                    have_low = 1'b0;
                end else if (!have_low) begin
                    low_byte = rx_byte;
                    have_low = 1'b1;
                end else begin
                    have_low = 1'b0;
                    decoded++;
                    if (sb.size() == 0) checkOutput("sbEmpty", 32'd1, 32'd0);
                    else checkOutput("rxWord", {16'd0, rx_byte, low_byte}, {16'd0, sb.pop_front()});
                end
            end
        end
    end

    // Main sequence: reset, single word, back-to-back, handshake hold, wrap-around, reset mid-frame.
    initial begin
        int t0;
        int t1;
        int n;
        int waited;
        logic saw_low;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        decoded   = 0;
        max_count = 0;
        req       = 1'b0;
        data      = '0;
        areset    = 1'b1;
        #1 areset = 1'b0;
        #1;
        checkOutput("rstTx",    {31'd0, tx},   32'd1);
        checkOutput("rstAck",   {31'd0, ack},  32'd0);
        checkOutput("rstBusy",  {31'd0, busy}, 32'd0);
        checkOutput("rstCount", {29'd0, fifo_count}, 32'd0);
        repeat (3) @(negedge clk);
        areset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idleTx", {31'd0, tx}, 32'd1);

        // Single word 0x1234.
        data = 16'h1234;
        req  = 1'b1;
        @(negedge clk);
        checkOutput("ackHigh",  {31'd0, ack}, 32'd1);
        checkOutput("countOne", {29'd0, fifo_count}, 32'd1);
        req = 1'b0;
        if (ack) sb.push_back(16'h1234);
        @(negedge clk);
        checkOutput("ackLow", {31'd0, ack}, 32'd0);
        checkOutput("txFall", {31'd0, tx},  32'd0);
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wordCycles", n, 32'd80);
        repeat (4) @(negedge clk);

        // Six words back to back with req held.
        max_count = 0;
        t0 = 0;
        t1 = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(16'hA000 + 16'(i * 16'h0111), 1'b1);
            if (i == 0) t0 = cyc;
            if (i == 4) t1 = cyc;
            if (i == 5) checkOutput("word6Blocked", (cyc - t1) >= 60, 32'd1);
        end
        req = 1'b0;
        checkOutput("b2bMaxCount", max_count, 32'd4);
        waited = 0;
        while (busy && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("b2bStreamCycles", cyc - t0, 32'd481);
        waitIdle();

        // Handshake hold: req stays high with the same word.
        data = 16'h00A5;
        req  = 1'b1;
        n    = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack) n++;
        end
        req = 1'b0;
        checkOutput("holdAccepts", n, 32'd4);
        for (int i = 0; i < n; i++) sb.push_back(16'h00A5);
        applyStimulus(16'h5A5A, 1'b0);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack) n++;
        end
        checkOutput("dropAccepts", n, 32'd0);
        waitIdle();

        // Wrap-around through the FIFO storage.
        max_count = 0;
        for (int i = 1; i <= 10; i++) applyStimulus(16'(i), 1'b1);
        req = 1'b0;
        waitIdle();
        checkOutput("wrapMaxCount", max_count, 32'd4);

        // Reset while word 1 is in its DATA bits and three words are queued.
        for (int i = 0; i < 4; i++) applyStimulus(16'hC0DE + 16'(i), 1'b1);
        req = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("preRstCount", {29'd0, fifo_count}, 32'd3);
        #1 areset = 1'b0;
        #1;
        checkOutput("midRstTx",    {31'd0, tx},   32'd1);
        checkOutput("midRstAck",   {31'd0, ack},  32'd0);
        checkOutput("midRstBusy",  {31'd0, busy}, 32'd0);
        checkOutput("midRstCount", {29'd0, fifo_count}, 32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        #2 areset = 1'b1;
        saw_low = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
        end
        checkOutput("postRstQuiet", {31'd0, saw_low}, 32'd0);

        checkOutput("sbDrained", sb.size(), 32'd0);
        checkOutput("decodedCount", decoded, 32'd22);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
